// File: rtl/ecg_sample_ring_buf_pkg.sv
// ecg_sample_ring_buf_pkg
//   Shared constants for the ECG sample ring buffer: storage geometry,
//   window/hop sizes, derived pointer widths and the fifo_ctrl_fsm state
//   encodings that the buffer decodes.
package ecg_sample_ring_buf_pkg;

    localparam int DATA_W          = 16;
    localparam int NUM_OF_MEM      = 8;
    localparam int LOG2_NUM_OF_MEM = 3;
    localparam int MEM_DEPTH       = 256;
    localparam int LOG2_MEM_DEPTH  = 8;
    localparam int WIN_LEN         = 100;
    localparam int LOG2_WIN        = 7;
    localparam int HOP             = 50;

    localparam int DEPTH = NUM_OF_MEM * MEM_DEPTH;
    localparam int AW    = LOG2_NUM_OF_MEM + LOG2_MEM_DEPTH;

    localparam logic [3:0] ST_FIRST_LOOP  = 4'b0000;
    localparam logic [3:0] ST_WAIT_TX_WIN = 4'b0001;
    localparam logic [3:0] ST_START_READ  = 4'b0010;
    localparam logic [3:0] ST_WAIT_LOOP   = 4'b0100;
    localparam logic [3:0] ST_WAIT_HYBD   = 4'b1000;

endpackage

// File: rtl/ecg_sample_ring_buf_if.sv
// ecg_sample_ring_buf_if
//   Sample stream in (s_valid/s_data/s_ready) and windowed read stream out
//   (m_valid/m_data/m_idx) of the ECG ring buffer.
//   master : sample source / read consumer side
//   slave  : the ring buffer itself
interface ecg_sample_ring_buf_if;
    import ecg_sample_ring_buf_pkg::*;

    logic                s_valid;
    logic [DATA_W-1:0]   s_data;
    logic                s_ready;
    logic                m_valid;
    logic [DATA_W-1:0]   m_data;
    logic [LOG2_WIN-1:0] m_idx;

    modport master (
        output s_valid, s_data,
        input  s_ready, m_valid, m_data, m_idx
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, m_valid, m_data, m_idx
    );

endinterface

// File: rtl/ecg_bank_ram.sv
// ecg_bank_ram
//   NUM_OF_MEM banks of MEM_DEPTH x DATA_W storage with one write port and
//   one synchronous read port (1-cycle latency). The upper address bits pick
//   the bank; the bank select is registered alongside the read so the output
//   mux lines up with the bank's read register.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid the cycle after re
module ecg_bank_ram
    import ecg_sample_ring_buf_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [LOG2_NUM_OF_MEM-1:0] wbank;
    logic [LOG2_MEM_DEPTH-1:0]  wrow;
    logic [LOG2_NUM_OF_MEM-1:0] rbank;
    logic [LOG2_MEM_DEPTH-1:0]  rrow;
    logic [LOG2_NUM_OF_MEM-1:0] rbank_q;
    logic [DATA_W-1:0]          bank_q [NUM_OF_MEM];

    assign wbank = waddr[AW-1:LOG2_MEM_DEPTH];
    assign wrow  = waddr[LOG2_MEM_DEPTH-1:0];
    assign rbank = raddr[AW-1:LOG2_MEM_DEPTH];
    assign rrow  = raddr[LOG2_MEM_DEPTH-1:0];

    for (genvar b = 0; b < NUM_OF_MEM; b++) begin : g_bank
        logic [DATA_W-1:0] mem [MEM_DEPTH];
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk) begin
            if (we && (wbank == LOG2_NUM_OF_MEM'(b))) begin
                mem[wrow] <= wdata;
            end
            if (re && (rbank == LOG2_NUM_OF_MEM'(b))) begin
                q <= mem[rrow];
            end
        end

        assign bank_q[b] = q;
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rbank_q <= rbank;
        end
    end

    assign rdata = bank_q[rbank_q];

endmodule

// File: rtl/ecg_sample_ring_buf.sv
// ecg_sample_ring_buf
//   Banked circular buffer between the ECG sample source and the feature
//   extraction read path. Stores incoming samples, serves the windowed reads
//   strobed by fifo_ctrl_fsm, and slides the window by HOP samples each time
//   the controller leaves START_READ.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : sample in / read data out (slave modport)
//   ctrl_state   : fifo_ctrl_fsm state, ctrl_toggle : read-phase toggle
//   sync_done    : one pulse when the first full window is stored
//   tx_w_done    : next window ready while controller waits in WAIT_TX_WIN
//   overflow     : sticky, a sample was dropped because the buffer was full
//   underrun     : sticky, a read or retire went past the stored samples
module ecg_sample_ring_buf
    import ecg_sample_ring_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    ecg_sample_ring_buf_if.slave bus,
    input  logic [3:0]           ctrl_state,
    input  logic                 ctrl_toggle,
    output logic                 sync_done,
    output logic                 tx_w_done,
    output logic                 overflow,
    output logic                 underrun
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] HOP_C   = CW'(HOP);
    localparam logic [CW-1:0] WIN_C   = CW'(WIN_LEN);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_base;
    logic [LOG2_WIN-1:0] rd_idx;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;
    logic [3:0]          prev_state;
    logic                sync_armed;
    logic                m_valid_q;
    logic [LOG2_WIN-1:0] m_idx_q;
    logic [DATA_W-1:0]   ram_rdata;
    logic [AW-1:0]       rd_addr;
    logic                ready;
    logic                wr_fire;
    logic                rd_stb;
    logic                win_end;
    logic                short_retire;

    // Held low during reset so the source never sees a ready buffer that
    // is about to be cleared.
    assign ready        = reset_n && (count < DEPTH_C);
    assign wr_fire      = bus.s_valid && ready;
    assign rd_stb       = (ctrl_state == ST_START_READ) && !ctrl_toggle;
    assign win_end      = (prev_state == ST_START_READ) && (ctrl_state != ST_START_READ);
    assign short_retire = win_end && (count < HOP_C);
    assign rd_addr      = rd_base + AW'(rd_idx);

    // A write landing on the retire cycle is still counted.
    always_comb begin
        count_nxt = count;
        if (win_end) begin
            if (short_retire) begin
                count_nxt = wr_fire ? CW'(1) : '0;
            end else begin
                count_nxt = count - HOP_C + (wr_fire ? CW'(1) : '0);
            end
        end else if (wr_fire) begin
            count_nxt = count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_base    <= '0;
            rd_idx     <= '0;
            count      <= '0;
            prev_state <= ST_FIRST_LOOP;
            sync_armed <= 1'b0;
            sync_done  <= 1'b0;
            tx_w_done  <= 1'b0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_idx_q    <= '0;
        end else begin
            prev_state <= ctrl_state;
            count      <= count_nxt;

            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (win_end) begin
                rd_base <= rd_base + AW'(HOP);
                rd_idx  <= '0;
            end else if (rd_stb) begin
                rd_idx <= rd_idx + LOG2_WIN'(1);
            end

            m_valid_q <= rd_stb;
            if (rd_stb) begin
                m_idx_q <= rd_idx;
            end

            if (bus.s_valid && !ready) begin
                overflow <= 1'b1;
            end

            if ((rd_stb && (CW'(rd_idx) >= count)) || short_retire) begin
                underrun <= 1'b1;
            end

            sync_done <= 1'b0;
            if (!sync_armed && (count >= WIN_C)) begin
                sync_done  <= 1'b1;
                sync_armed <= 1'b1;
            end

            tx_w_done <= (ctrl_state == ST_WAIT_TX_WIN) && (count >= WIN_C);
        end
    end

    ecg_bank_ram u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (bus.s_data),
        .re    (rd_stb),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign bus.s_ready = ready;
    assign bus.m_valid = m_valid_q;
    // Idle cycles (and the first cycles after reset, before any read has
    // loaded the bank registers) present zero rather than stale RAM output.
    assign bus.m_data  = m_valid_q ? ram_rdata : '0;
    assign bus.m_idx   = m_idx_q;

endmodule

// File: tb/tb_ecg_sample_ring_buf.sv
// tb_ecg_sample_ring_buf
//   Directed bench for ecg_sample_ring_buf: first window sync, alternate
//   strobed reads, window slide and tx_w_done, address wrap, overflow,
//   write on the retire cycle, mid-window reset and underrun.
`timescale 1ns/1ps
module tb_ecg_sample_ring_buf;
    import ecg_sample_ring_buf_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [3:0] ctrl_state;
    logic       ctrl_toggle;
    logic       sync_done;
    logic       tx_w_done;
    logic       overflow;
    logic       underrun;

    ecg_sample_ring_buf_if bus ();

    ecg_sample_ring_buf dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .ctrl_state  (ctrl_state),
        .ctrl_toggle (ctrl_toggle),
        .sync_done   (sync_done),
        .tx_w_done   (tx_w_done),
        .overflow    (overflow),
        .underrun    (underrun)
    );

    int checks      = 0;
    int failures    = 0;
    int next_wr     = 0;
    int sync_pulses = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sync_done === 1'b1) sync_pulses++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_samples(input int n);
        bus.s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.s_data = 16'(next_wr);
            tick();
            next_wr++;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic read_window(input int base, input bit alt, input bit wr_on_end);
        int j;
        int ncyc;
        j    = 0;
        ncyc = alt ? 200 : 100;
        ctrl_state = ST_START_READ;
        for (int k = 0; k < ncyc; k++) begin
            ctrl_toggle = alt ? k[0] : 1'b0;
            tick();
            if (!ctrl_toggle) begin
                chk("rd_valid", bus.m_valid, 1);
                chk("rd_data", bus.m_data, (base + j) & 32'hFFFF);
                chk("rd_idx", bus.m_idx, j);
                j++;
            end else begin
                chk("rd_gap", bus.m_valid, 0);
            end
        end
        ctrl_state  = ST_WAIT_LOOP;
        ctrl_toggle = 1'b0;
        if (wr_on_end) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(next_wr);
        end
        tick();
        if (wr_on_end) begin
            bus.s_valid = 1'b0;
            next_wr++;
        end
        chk("rd_end_valid", bus.m_valid, 0);
        chk("no_underrun", underrun, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        ctrl_state  = ST_FIRST_LOOP;
        ctrl_toggle = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        tick();
        tick();
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_idx", bus.m_idx, 0);
        chk("rst_sync", sync_done, 0);
        chk("rst_tx", tx_w_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unr", underrun, 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_s_ready", bus.s_ready, 1);

        // First window: samples 0..99, sync pulse one cycle after count=100.
        bus.s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.s_data = 16'(next_wr);
            tick();
            next_wr++;
            chk("sync_early", sync_done, 0);
        end
        bus.s_valid = 1'b0;
        tick();
        chk("sync_pulse", sync_done, 1);
        tick();
        chk("sync_single", sync_done, 0);

        // Alternate strobes: data 0..99 on even cycles.
        read_window(0, 1'b1, 1'b0);

        // Slide: count 50 after retire, tx_w_done once count reaches 100.
        ctrl_state = ST_WAIT_TX_WIN;
        tick();
        chk("tx_low_count50", tx_w_done, 0);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.s_data = 16'(next_wr);
            tick();
            next_wr++;
            chk("tx_early", tx_w_done, 0);
        end
        bus.s_valid = 1'b0;
        tick();
        chk("tx_rise", tx_w_done, 1);
        read_window(50, 1'b1, 1'b0);

        // Advance windows up to base 2000, then read across the 2047->0 wrap.
        for (int base = 100; base <= 1950; base += HOP) begin
            write_samples(base + WIN_LEN - next_wr);
            read_window(base, 1'b0, 1'b0);
        end
        write_samples(2000 + WIN_LEN - next_wr);
        read_window(2000, 1'b1, 1'b0);
        chk("sync_no_repeat", sync_pulses, 1);

        // Fill to 2048 (count 50 now), then one sample is dropped.
        write_samples(1998);
        chk("full_s_ready", bus.s_ready, 0);
        chk("full_no_ovf", overflow, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hDEAD;
        tick();
        bus.s_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        tick();
        chk("ovf_sticky", overflow, 1);
        chk("full_s_ready2", bus.s_ready, 0);
        read_window(2050, 1'b0, 1'b0);
        chk("ready_after_retire", bus.s_ready, 1);

        // Mid-window reset.
        ctrl_state  = ST_START_READ;
        ctrl_toggle = 1'b0;
        tick();
        tick();
        chk("mid_valid", bus.m_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid_async", bus.m_valid, 0);
        tick();
        chk("rst_mid_valid", bus.m_valid, 0);
        chk("rst_mid_ovf", overflow, 0);
        ctrl_state = ST_FIRST_LOOP;
        reset_n    = 1'b1;
        next_wr    = 0;
        #1;
        chk("rearm_ready", bus.s_ready, 1);

        // Re-armed sync after 100 writes from empty.
        bus.s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.s_data = 16'(next_wr);
            tick();
            next_wr++;
            chk("rearm_sync_early", sync_done, 0);
        end
        bus.s_valid = 1'b0;
        tick();
        chk("rearm_sync_pulse", sync_done, 1);

        // Write on the retire cycle: count = 100 + 1 - 50 = 51.
        read_window(0, 1'b1, 1'b1);
        ctrl_state = ST_WAIT_TX_WIN;
        write_samples(48);
        chk("wr_retire_tx98", tx_w_done, 0);
        write_samples(1);
        chk("wr_retire_tx99", tx_w_done, 0);
        tick();
        chk("wr_retire_tx100", tx_w_done, 1);
        read_window(50, 1'b0, 1'b0);

        // Underrun: only 50 stored, strobe index 50 overruns.
        ctrl_state  = ST_START_READ;
        ctrl_toggle = 1'b0;
        for (int j = 0; j <= 50; j++) begin
            tick();
            chk("unr_flag", underrun, (j >= 50) ? 1 : 0);
            if (j < 50) chk("unr_data", bus.m_data, 100 + j);
        end
        ctrl_state = ST_WAIT_LOOP;
        tick();
        chk("unr_sticky", underrun, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
